// File: rtl/minv_x1_ctrl_pkg.sv
// Shared definitions for the X1 operand register sequencer.
//   WORD_W  : width of one register slice / stream word
//   NWORDS  : slices per 256-bit operand
//   SHAMT_W : width of the per-command shift count
//   cmd_e   : host command encodings
//   state_e : sequencer states
package minv_pkg;

    localparam int WORD_W  = 16;
    localparam int NWORDS  = 16;
    localparam int SHAMT_W = 8;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_SHR  = 2'b01,
        CMD_SET1 = 2'b10,
        CMD_READ = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SET   = 3'd3,
        ST_READ  = 3'd4
    } state_e;

endpackage

// File: rtl/minv_x1_ctrl_if.sv
// Host-side bundle of the X1 sequencer: command handshake, load stream,
// read stream and the completion pulse.
//   master : the host (issues commands, supplies load words, takes read words)
//   slave  : the sequencer
interface minv_x1_ctrl_if
    import minv_pkg::*;
();

    logic [1:0]         cmd;
    logic [SHAMT_W-1:0] cmd_shamt;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [WORD_W-1:0]  din;
    logic               din_valid;
    logic               din_ready;
    logic [WORD_W-1:0]  dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               done;

    modport master (
        output cmd, cmd_shamt, cmd_valid, din, din_valid, dout_ready,
        input  cmd_ready, din_ready, dout, dout_valid, done
    );

    modport slave (
        input  cmd, cmd_shamt, cmd_valid, din, din_valid, dout_ready,
        output cmd_ready, din_ready, dout, dout_valid, done
    );

endinterface

// File: rtl/minv_word_cnt.sv
// Modulo-MOD up-counter used to step through the register slices.
//   clk, rst : clock, asynchronous active-high reset
//   en_i     : advance by one this cycle
//   tc_o     : counter sits at MOD-1 (the next enabled step wraps to 0)
module minv_word_cnt #(
    parameter int MOD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (MOD > 1) ? $clog2(MOD) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o  = (cnt_q == CW'(MOD - 1));
    assign cnt_d = tc_o ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/minv_x1_ctrl.sv
// Sequencer owning every control input of the 256-bit X1 operand register.
//   clk, rst   : clock, asynchronous active-high reset
//   host       : command / load-stream / read-stream handshakes and done pulse
//   shift_fill : bit shifted into bit 255 on each right shift
//   x_lsw      : current least-significant slice of the register
//   x_we, x_sel_cyc, x_sel_rs, x_set, x_regin, x_bit256 : register controls
module minv_x1_ctrl
    import minv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    minv_x1_ctrl_if.slave     host,
    input  logic              shift_fill,
    input  logic [WORD_W-1:0] x_lsw,
    output logic              x_we,
    output logic              x_sel_cyc,
    output logic              x_sel_rs,
    output logic              x_set,
    output logic [WORD_W-1:0] x_regin,
    output logic              x_bit256
);

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               done_q, done_d;

    logic               wcnt_en;
    logic               wcnt_tc;

    logic               cmd_ready_c;
    logic               din_ready_c;
    logic [WORD_W-1:0]  dout_c;
    logic               dout_valid_c;

    // One counter serves both LOAD and READ; it wraps to 0 on the 16th
    // step, so it is always 0 again when a command begins.
    minv_word_cnt #(
        .MOD (NWORDS)
    ) u_word_cnt (
        .clk  (clk),
        .rst  (rst),
        .en_i (wcnt_en),
        .tc_o (wcnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shamt_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shamt_q <= shamt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shamt_d      = shamt_q;
        done_d       = 1'b0;
        wcnt_en      = 1'b0;
        cmd_ready_c  = 1'b0;
        din_ready_c  = 1'b0;
        dout_c       = '0;
        dout_valid_c = 1'b0;
        x_we         = 1'b0;
        x_sel_cyc    = 1'b0;
        x_sel_rs     = 1'b0;
        x_set        = 1'b0;
        x_regin      = '0;
        x_bit256     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Held low while reset is asserted so nothing is taken
                // until reset has been released.
                cmd_ready_c = !rst;
                if (host.cmd_valid && !rst) begin
                    case (host.cmd)
                        CMD_LOAD: state_d = ST_LOAD;
                        CMD_SHR: begin
                            if (host.cmd_shamt != '0) begin
                                state_d = ST_SHIFT;
                                shamt_d = host.cmd_shamt;
                            end else begin
                                // Zero-length shift completes at once.
                                done_d = 1'b1;
                            end
                        end
                        CMD_SET1: state_d = ST_SET;
                        CMD_READ: state_d = ST_READ;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end

            ST_LOAD: begin
                din_ready_c = 1'b1;
                x_regin     = host.din;
                if (host.din_valid) begin
                    // Each word enters the top slice; the bank shifts down
                    // by one slice, so word 0 ends in the LS slice.
                    x_we    = 1'b1;
                    wcnt_en = 1'b1;
                    if (wcnt_tc) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                x_we     = 1'b1;
                x_sel_rs = 1'b1;
                x_bit256 = shift_fill;
                shamt_d  = shamt_q - SHAMT_W'(1);
                if (shamt_q == SHAMT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            ST_SET: begin
                x_we    = 1'b1;
                x_set   = 1'b1;
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end

            ST_READ: begin
                dout_c       = x_lsw;
                dout_valid_c = 1'b1;
                if (host.dout_ready) begin
                    // A 16-bit rotate exposes the next slice; 16 of them
                    // restore the original register value.
                    x_we      = 1'b1;
                    x_sel_cyc = 1'b1;
                    wcnt_en   = 1'b1;
                    if (wcnt_tc) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign host.cmd_ready  = cmd_ready_c;
    assign host.din_ready  = din_ready_c;
    assign host.dout       = dout_c;
    assign host.dout_valid = dout_valid_c;
    assign host.done       = done_q;

endmodule

// File: tb/tb_minv_x1_ctrl.sv
module tb_minv_x1_ctrl;
    import minv_pkg::*;

    logic        clk;
    logic        rst;
    logic        shift_fill;
    logic [15:0] x_lsw;
    logic        x_we, x_sel_cyc, x_sel_rs, x_set, x_bit256;
    logic [15:0] x_regin;

    logic [255:0] xreg;
    logic [15:0]  exp_w [16];

    int total = 0;
    int bad   = 0;

    minv_x1_ctrl_if bus ();

    minv_x1_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .host       (bus),
        .shift_fill (shift_fill),
        .x_lsw      (x_lsw),
        .x_we       (x_we),
        .x_sel_cyc  (x_sel_cyc),
        .x_sel_rs   (x_sel_rs),
        .x_set      (x_set),
        .x_regin    (x_regin),
        .x_bit256   (x_bit256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural X1 register bank driven by the sequencer's controls.
    always @(posedge clk) begin
        if (x_we) begin
            if (x_set)          xreg <= 256'd1;
            else if (x_sel_rs)  xreg <= {x_bit256, xreg[255:1]};
            else if (x_sel_cyc) xreg <= {xreg[15:0], xreg[255:16]};
            else                xreg <= {x_regin, xreg[255:16]};
        end
    end
    assign x_lsw = xreg[15:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Offer a command at a falling edge; returns at the next falling edge
    // with the command taken and cmd_valid dropped.
    task automatic send_cmd(input logic [1:0] c, input logic [7:0] sh);
        bus.cmd       = c;
        bus.cmd_shamt = sh;
        bus.cmd_valid = 1'b1;
        #1 chk("cmd_ready", bus.cmd_ready, 1);
        $display("cmd=%0d shamt=%0d offered at %0t", c, sh, $time);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic load_body(input string tag);
        for (int i = 0; i < 16; i++) begin
            bus.din       = exp_w[i];
            bus.din_valid = 1'b1;
            #1;
            chk({tag, "_din_ready"}, bus.din_ready, 1);
            chk({tag, "_we"}, x_we, 1);
            chk({tag, "_regin"}, x_regin, exp_w[i]);
            chk({tag, "_busy"}, bus.cmd_ready, 0);
            chk({tag, "_no_done"}, bus.done, 0);
            @(negedge clk);
        end
        bus.din_valid = 1'b0;
        #1 chk({tag, "_done"}, bus.done, 1);
        $display("load %s complete at %0t", tag, $time);
    endtask

    task automatic read_all(input string tag);
        send_cmd(CMD_READ, 8'd0);
        for (int i = 0; i < 16; i++) begin
            bus.dout_ready = 1'b1;
            #1;
            chk({tag, "_valid"}, bus.dout_valid, 1);
            chk({tag, "_word"}, bus.dout, exp_w[i]);
            chk({tag, "_we"}, x_we, 1);
            chk({tag, "_cyc"}, x_sel_cyc, 1);
            @(negedge clk);
        end
        bus.dout_ready = 1'b0;
        #1;
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_idle"}, bus.cmd_ready, 1);
        @(negedge clk);
        #1 chk({tag, "_done_drop"}, bus.done, 0);
        $display("read %s complete at %0t", tag, $time);
    endtask

    task automatic shift_cmd(input string tag, input logic [7:0] sh, input logic fill);
        shift_fill = fill;
        send_cmd(CMD_SHR, sh);
        for (int k = 0; k < int'(sh); k++) begin
            #1;
            chk({tag, "_we"}, x_we, 1);
            chk({tag, "_rs"}, x_sel_rs, 1);
            chk({tag, "_fill"}, x_bit256, fill);
            @(negedge clk);
        end
        #1;
        chk({tag, "_we_end"}, x_we, 0);
        chk({tag, "_done"}, bus.done, 1);
        @(negedge clk);
        $display("shift %s complete at %0t", tag, $time);
    endtask

    initial begin
        int nx;
        int cyc;

        rst            = 1'b1;
        shift_fill     = 1'b0;
        bus.cmd        = 2'b00;
        bus.cmd_shamt  = '0;
        bus.cmd_valid  = 1'b0;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        xreg           = '0;

        // Reset state
        #1;
        chk("rst_we", x_we, 0);
        chk("rst_din_ready", bus.din_ready, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_done", bus.done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);

        // LOAD 0x0001..0x0010, then straight READ
        for (int i = 0; i < 16; i++) exp_w[i] = 16'(i + 1);
        send_cmd(CMD_LOAD, 8'd0);
        load_body("ld1");
        @(negedge clk);
        #1 chk("ld1_done_drop", bus.done, 0);
        read_all("rd1");

        // READ with dout_ready toggling
        send_cmd(CMD_READ, 8'd0);
        nx  = 0;
        cyc = 0;
        while (nx < 16 && cyc < 64) begin
            bus.dout_ready = (cyc % 2 == 0);
            #1;
            chk("tog_word", bus.dout, exp_w[nx]);
            chk("tog_we", x_we, bus.dout_ready);
            if (bus.dout_ready) nx++;
            cyc++;
            @(negedge clk);
        end
        bus.dout_ready = 1'b0;
        chk("tog_xfers", nx, 16);
        chk("tog_cycles", cyc, 31);
        #1 chk("tog_done", bus.done, 1);
        @(negedge clk);
        read_all("rd_rot");

        // Shifts
        for (int i = 0; i < 16; i++) exp_w[i] = 16'h0000;
        exp_w[0] = 16'h0002;
        send_cmd(CMD_LOAD, 8'd0);
        load_body("ld2");
        @(negedge clk);
        shift_cmd("shr1", 8'd1, 1'b0);
        exp_w[0] = 16'h0001;
        read_all("rd_shr1");
        shift_cmd("shr1f", 8'd1, 1'b1);
        exp_w[0]  = 16'h0000;
        exp_w[15] = 16'h8000;
        read_all("rd_shr1f");
        shift_cmd("shr4", 8'd4, 1'b0);
        exp_w[15] = 16'h0800;
        read_all("rd_shr4");

        // Zero-length shift
        send_cmd(CMD_SHR, 8'd0);
        #1;
        chk("shr0_we", x_we, 0);
        chk("shr0_done", bus.done, 1);
        chk("shr0_ready", bus.cmd_ready, 1);
        @(negedge clk);
        #1 chk("shr0_done_drop", bus.done, 0);
        read_all("rd_shr0");

        // SET1
        send_cmd(CMD_SET1, 8'd0);
        #1;
        chk("set_x_set", x_set, 1);
        chk("set_we", x_we, 1);
        @(negedge clk);
        #1;
        chk("set_done", bus.done, 1);
        chk("set_x_set_drop", x_set, 0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) exp_w[i] = 16'h0000;
        exp_w[0] = 16'h0001;
        read_all("rd_set");

        // SET1 held off during LOAD, accepted in the done cycle
        for (int i = 0; i < 16; i++) exp_w[i] = 16'(16'hA000 + i);
        send_cmd(CMD_LOAD, 8'd0);
        bus.cmd       = CMD_SET1;
        bus.cmd_valid = 1'b1;
        load_body("ld3");
        chk("hold_ready_at_done", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1 chk("hold_set_taken", x_set, 1);
        @(negedge clk);
        #1 chk("hold_set_done", bus.done, 1);
        @(negedge clk);
        for (int i = 0; i < 16; i++) exp_w[i] = 16'h0000;
        exp_w[0] = 16'h0001;
        read_all("rd_hold");

        // Reset after 5 of 16 load words
        for (int i = 0; i < 16; i++) exp_w[i] = 16'(16'h5100 + i);
        send_cmd(CMD_LOAD, 8'd0);
        for (int i = 0; i < 5; i++) begin
            bus.din       = exp_w[i];
            bus.din_valid = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_we", x_we, 0);
        chk("mid_rst_din_ready", bus.din_ready, 0);
        chk("mid_rst_regin", x_regin, 0);
        chk("mid_rst_done", bus.done, 0);
        bus.din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_rst_idle", bus.cmd_ready, 1);
        @(negedge clk);
        send_cmd(CMD_LOAD, 8'd0);
        load_body("ld4");
        @(negedge clk);
        read_all("rd_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
